serpent_lt_stage: RTL and testbench

Registered Serpent round back-end that sits directly downstream of the bit-sliced S-box layer. It accepts the four 32-bit S-box output words with a valid/ready handshake. For rounds 0–30 it applies the Serpent linear transformation (LT); for round 31 it XORs in the final subkey K32 instead. A two-entry elastic buffer (output register plus skid register) sustains one block per clock while keeping the upstream ready registered.

---
 rtl/serpent_lt_stage.sv | 149 ++++++++++++++
 tb/tb_serpent_lt_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serpent_lt_stage.sv
// serpent_lt_stage
// Back end of one Serpent round, placed right after the bit-sliced S-box layer.
// Rounds 0-30 apply the linear transformation (LT). Round 31 XORs in the final
// subkey K32 and does not apply the LT. The data is transformed on the input
// side, so both registers below hold words that are already transformed.
// A two-entry elastic buffer (output register plus skid register) passes one
// block per clock. Because of the skid register, o_in_ready can come straight
// from a flop.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_flush             synchronous discard of both buffered entries
//   i_in_valid/o_in_ready, i_word0..3, i_round, i_final_key   upstream side
//   o_out_valid/i_out_ready, o_word0..3, o_round, o_data       downstream side
//
// Buffer occupancy, taken from the two valid flops:
//   state | meaning
//   EMPTY | out reg invalid, skid empty
//   ONE   | out reg valid, skid empty
//   FULL  | out reg and skid both valid (o_in_ready low)
module serpent_lt_stage (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [31:0]  i_word0,
  input  logic [31:0]  i_word1,
  input  logic [31:0]  i_word2,
  input  logic [31:0]  i_word3,
  input  logic [4:0]   i_round,
  input  logic [127:0] i_final_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [31:0]  o_word0,
  output logic [31:0]  o_word1,
  output logic [31:0]  o_word2,
  output logic [31:0]  o_word3,
  output logic [4:0]   o_round,
  output logic [127:0] o_data
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  logic [31:0]  x0, x1, x2, x3;
  logic [127:0] xf_data;

  always_comb begin
    x0 = rotl(i_word0, 13);
    x2 = rotl(i_word2, 3);
    x1 = i_word1 ^ x0 ^ x2;
    x3 = i_word3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    if (i_round == 5'd31) begin
      xf_data = {i_word3, i_word2, i_word1, i_word0} ^ i_final_key;
    end else begin
      xf_data = {x3, x2, x1, x0};
    end
  end

  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;
  logic [4:0]   out_round_q, out_round_d;
  logic         skid_valid_q, skid_valid_d;
  logic [127:0] skid_data_q, skid_data_d;
  logic [4:0]   skid_round_q, skid_round_d;
  logic         in_ready_q, in_ready_d;

  logic accept, emit;

  assign accept = i_in_valid & in_ready_q;
  assign emit   = out_valid_q & i_out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_round_d  = out_round_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_round_d = skid_round_q;

    if (i_flush) begin
      // An accept in the same cycle as a flush is dropped. An emit in that
      // cycle has already been taken downstream, so nothing else is needed.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = xf_data;
        out_round_d = i_round;
      end
    end else if (!skid_valid_q) begin
      if (accept && emit) begin
        out_data_d  = xf_data;
        out_round_d = i_round;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = xf_data;
        skid_round_d = i_round;
      end else if (emit) begin
        out_valid_d = 1'b0;
      end
    end else if (emit) begin
      out_data_d   = skid_data_q;
      out_round_d  = skid_round_q;
      skid_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_round_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_round_q <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_round_q  <= out_round_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_round_q <= skid_round_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_data      = out_data_q;
  assign o_round     = out_round_q;
  assign o_word0     = out_data_q[31:0];
  assign o_word1     = out_data_q[63:32];
  assign o_word2     = out_data_q[95:64];
  assign o_word3     = out_data_q[127:96];

endmodule

// File: tb/tb_serpent_lt_stage.sv
// Testbench for serpent_lt_stage. A scoreboard queue receives a model result
// for every accepted block. A monitor pops the queue on each emit and checks
// occupancy, ordering and stall stability.
module tb_serpent_lt_stage;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [31:0]  i_word0 = '0, i_word1 = '0, i_word2 = '0, i_word3 = '0;
  logic [4:0]   i_round = '0;
  logic [127:0] i_final_key = '0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [31:0]  o_word0, o_word1, o_word2, o_word3;
  logic [4:0]   o_round;
  logic [127:0] o_data;

  serpent_lt_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_word0(i_word0), .i_word1(i_word1), .i_word2(i_word2), .i_word3(i_word3),
    .i_round(i_round), .i_final_key(i_final_key),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_word0(o_word0), .o_word1(o_word1), .o_word2(o_word2), .o_word3(o_word3),
    .o_round(o_round), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [132:0] sb[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  // Reference model: the round transform on a 4-word array.
  function automatic logic [127:0] model(input logic [127:0] w, input logic [4:0] r,
                                          input logic [127:0] k);
    logic [31:0] x[4];
    for (int i = 0; i < 4; i++) x[i] = w[32*i +: 32];
    if (r == 5'd31) return w ^ k;
    x[0] = rl(x[0], 13);
    x[2] = rl(x[2], 3);
    x[1] = x[1] ^ x[0] ^ x[2];
    x[3] = x[3] ^ x[2] ^ 32'(x[0] * 8);
    x[1] = rl(x[1], 1);
    x[3] = rl(x[3], 7);
    x[0] = x[0] ^ x[1] ^ x[3];
    x[2] = x[2] ^ x[3] ^ 32'(x[1] * 128);
    x[0] = rl(x[0], 5);
    x[2] = rl(x[2], 22);
    return {x[3], x[2], x[1], x[0]};
  endfunction

  // One clock of stimulus. Inputs change at the negedge. Accept is decided
  // just before the posedge, and the push happens just after it, so it cannot
  // race the monitor.
  task automatic cycle(input bit v, input logic [127:0] w, input logic [4:0] r,
                       input logic [127:0] k, input bit rdy, input bit fl, output bit acc);
    @(negedge i_clk);
    i_in_valid = v;
    {i_word3, i_word2, i_word1, i_word0} = w;
    i_round = r;
    i_final_key = k;
    i_out_ready = rdy;
    i_flush = fl;
    #4;
    acc = v && o_in_ready && i_rst_n && !fl;
    @(posedge i_clk);
    #1;
    if (acc) sb.push_back({r, model(w, r, k)});
  endtask

  // Monitor: samples 1 time unit before each posedge.
  bit           prev_stall = 1'b0;
  logic [132:0] prev_out;
  initial begin
    forever begin
      @(negedge i_clk);
      #4;
      if (!i_rst_n) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        chk("out_valid_occupancy", 160'(o_out_valid), 160'(sb.size() > 0));
        chk("in_ready_occupancy", 160'(o_in_ready), 160'(sb.size() < 2));
        if (prev_stall) chk("stall_stable", 160'({o_round, o_data}), 160'(prev_out));
        if (o_out_valid && i_out_ready) begin
          if (sb.size() == 0) begin
            chk("emit_without_entry", 160'(1), 160'(0));
          end else begin
            logic [132:0] e;
            e = sb.pop_front();
            chk("emit_data", 160'({o_round, o_data}), 160'(e));
            chk("o_data_words", 160'(o_data), 160'({o_word3, o_word2, o_word1, o_word0}));
          end
        end
        prev_stall = o_out_valid && !i_out_ready;
        prev_out = {o_round, o_data};
        if (i_flush) sb.delete();
      end
    end
  end

  initial begin
    bit acc;
    int cyc;
    logic [127:0] key;
    logic [127:0] rw;
    key = 128'h0123456789ABCDEF_FEDCBA9876543210;

    // Reset, then idle.
    #22;
    chk("reset_out_valid", 160'(o_out_valid), 160'(0));
    chk("reset_in_ready", 160'(o_in_ready), 160'(1));
    chk("reset_data", 160'({o_round, o_data}), 160'(0));
    i_rst_n = 1'b1;
    cycle(0, '0, 0, '0, 1, 0, acc);

    // Known LT answer for a single set bit.
    cycle(1, 128'h1, 0, '0, 1, 0, acc);
    chk("vec_latency_valid", 160'(o_out_valid), 160'(1));
    chk("vec_words", 160'({o_word3, o_word2, o_word1, o_word0}),
        160'({32'h00800000, 32'h00002800, 32'h00004000, 32'h100C0000}));
    chk("vec_round", 160'(o_round), 160'(0));

    // Round 31 on zero words gives the key unchanged.
    cycle(1, '0, 31, key, 1, 0, acc);
    chk("final_key", 160'(o_data), 160'(key));
    cycle(0, '0, 0, '0, 1, 0, acc);

    // Four back-to-back blocks, downstream stalled for cycles 2..4.
    cyc = 0;
    for (int b = 0; b < 4; b++) begin
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        rw = {$urandom, $urandom, $urandom, $urandom};
        cycle(1, rw, 5'(b), key, !(cyc >= 2 && cyc < 5), 0, acc);
        if (cyc == 2) chk("ready_drop_when_full", 160'(o_in_ready), 160'(0));
        cyc++;
      end
      if (!acc) chk("stall_accept_timeout", 160'(0), 160'(1));
    end
    for (int t = 0; t < 4; t++) cycle(0, '0, 0, '0, 1, 0, acc);

    // Fill to FULL, then flush while a block is also offered.
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 3, key, 0, 0, acc);
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 4, key, 0, 0, acc);
    chk("full_in_ready", 160'(o_in_ready), 160'(0));
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 7, key, 0, 1, acc);
    chk("flush_out_valid", 160'(o_out_valid), 160'(0));
    chk("flush_in_ready", 160'(o_in_ready), 160'(1));
    for (int t = 0; t < 2; t++) cycle(0, '0, 0, '0, 1, 0, acc);

    // Asynchronous reset while FULL.
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 8, key, 0, 0, acc);
    cycle(1, {$urandom, $urandom, $urandom, $urandom}, 9, key, 0, 0, acc);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 160'(o_out_valid), 160'(0));
    chk("midrst_in_ready", 160'(o_in_ready), 160'(1));
    chk("midrst_data", 160'({o_round, o_data}), 160'(0));
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    rw = {$urandom, $urandom, $urandom, $urandom};
    cycle(1, rw, 5, key, 1, 0, acc);
    chk("post_rst_valid", 160'(o_out_valid), 160'(1));
    chk("post_rst_block", 160'({o_round, o_data}), 160'({5'd5, model(rw, 5, key)}));

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      rw = {$urandom, $urandom, $urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, rw, 5'($urandom_range(0, 31)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, acc);
    end

    // Drain, with a bounded number of cycles.
    for (int t = 0; t < 10 && sb.size() > 0; t++) cycle(0, '0, 0, '0, 1, 0, acc);
    chk("drain_empty", 160'(sb.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
